// File: rtl/sdrc_wb_arb.sv
// Two-master Wishbone arbiter in front of the SDRAM controller slave port.
// Optional per-grant watchdog enabled by defining SDRC_WB_ARB_TMO_EN.
module sdrc_wb_arb #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int TMO = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [AW-1:0]   m0_addr_i,
   input  logic [DW-1:0]   m0_dat_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic [2:0]      m0_cti_i,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   output logic [DW-1:0]   m0_dat_o,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [AW-1:0]   m1_addr_i,
   input  logic [DW-1:0]   m1_dat_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic [2:0]      m1_cti_i,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic [DW-1:0]   m1_dat_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [AW-1:0]   s_addr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic [2:0]      s_cti_o,
   input  logic            s_ack_i,
   input  logic [DW-1:0]   s_dat_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   last, last_nxt;
   logic   tmo_hit;

   if (TMO < 1 || TMO > 255) begin : g_tmo_range
      $error("sdrc_wb_arb: TMO must be in 1..255");
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

`ifdef SDRC_WB_ARB_TMO_EN
   logic [7:0] tmo_cnt;

   // Counts unacknowledged strobe cycles of the current grant only.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
         tmo_cnt <= '0;
      else if (state_nxt == IDLE || s_ack_i)
         tmo_cnt <= '0;
      else if (s_stb_o)
         tmo_cnt <= tmo_cnt + 8'd1;
   end

   assign tmo_hit = (state != IDLE) && (tmo_cnt == 8'(TMO));
`else
   assign tmo_hit = 1'b0;
`endif

   // Grant is held for the whole cycle; the loser waits out one IDLE cycle.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      unique case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i)
               state_nxt = last ? GNT0 : GNT1;
            else if (m0_cyc_i)
               state_nxt = GNT0;
            else if (m1_cyc_i)
               state_nxt = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i || tmo_hit) begin
               state_nxt = IDLE;
               last_nxt  = 1'b0;
            end
         end
         GNT1: begin
            if (!m1_cyc_i || tmo_hit) begin
               state_nxt = IDLE;
               last_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      s_cti_o  = m0_cti_i;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_err_o = 1'b0;
      unique case (state)
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            m0_ack_o = s_ack_i;
            m0_err_o = tmo_hit;
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_addr_o = m1_addr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_cti_o  = m1_cti_i;
            m1_ack_o = s_ack_i;
            m1_err_o = tmo_hit;
         end
         default: ;
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

endmodule
